// File: rtl/button_event.sv
// Push-button gesture decoder: turns debounced press/release pulses into
// click, double-click, long-press and auto-repeat events.
module button_event #(
    parameter int CNT_W        = 24,
    parameter int LONG_TICKS   = 12000000,
    parameter int DCLICK_TICKS = 3000000,
    parameter int REPEAT_TICKS = 2400000
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic PB_down,
    input  logic PB_up,
    output logic CLICK,
    output logic DCLICK,
    output logic LONG,
    output logic REPEAT,
    output logic HELD
);

    typedef enum logic [2:0] {IDLE, PRESS, GAP, PRESS2, LONGH} state_t;

    localparam int LONG_M1   = LONG_TICKS - 1;
    localparam int DCLICK_M1 = DCLICK_TICKS - 1;
    localparam int REPEAT_M1 = REPEAT_TICKS - 1;
    localparam logic [CNT_W-1:0] LONG_TERM   = LONG_M1[CNT_W-1:0];
    localparam logic [CNT_W-1:0] DCLICK_TERM = DCLICK_M1[CNT_W-1:0];
    localparam logic [CNT_W-1:0] REPEAT_TERM = REPEAT_M1[CNT_W-1:0];

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             click_next, dclick_next, long_next, repeat_next, held_next;
    logic             down_evt, up_evt;

    // Coincident press and release cancel each other out entirely.
    assign down_evt = PB_down & ~PB_up;
    assign up_evt   = PB_up & ~PB_down;

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg + 1'b1;
        click_next  = 1'b0;
        dclick_next = 1'b0;
        long_next   = 1'b0;
        repeat_next = 1'b0;
        case (state_reg)
            IDLE: begin
                cnt_next = '0;
                if (down_evt) state_next = PRESS;
            end
            PRESS: begin
                if (up_evt) begin
                    state_next = GAP;
                end else if (cnt_reg == LONG_TERM) begin
                    state_next = LONGH;
                    long_next  = 1'b1;
                end
            end
            GAP: begin
                if (down_evt) begin
                    state_next = PRESS2;
                end else if (cnt_reg == DCLICK_TERM) begin
                    state_next = IDLE;
                    click_next = 1'b1;
                end
            end
            PRESS2: begin
                if (up_evt) begin
                    state_next  = IDLE;
                    dclick_next = 1'b1;
                end else if (cnt_reg == LONG_TERM) begin
                    // The first click is final once the second press turns long.
                    state_next = LONGH;
                    click_next = 1'b1;
                    long_next  = 1'b1;
                end
            end
            LONGH: begin
                if (up_evt) begin
                    state_next = IDLE;
                end else if (cnt_reg == REPEAT_TERM) begin
                    repeat_next = 1'b1;
                    cnt_next    = '0;
                end
            end
            default: state_next = IDLE;
        endcase
        if (state_next != state_reg) cnt_next = '0;
        held_next = (state_next == PRESS) || (state_next == PRESS2) || (state_next == LONGH);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            CLICK     <= 1'b0;
            DCLICK    <= 1'b0;
            LONG      <= 1'b0;
            REPEAT    <= 1'b0;
            HELD      <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            CLICK     <= click_next;
            DCLICK    <= dclick_next;
            LONG      <= long_next;
            REPEAT    <= repeat_next;
            HELD      <= held_next;
        end
    end

endmodule

// File: tb/tb_button_event.sv
// Directed bench for button_event with short tick parameters; every output
// is compared each cycle against hand-computed event timelines.
module tb_button_event;

    logic CLK = 1'b0;
    logic RST_N = 1'b0;
    logic PB_down = 1'b0;
    logic PB_up = 1'b0;
    logic CLICK, DCLICK, LONG, REPEAT, HELD;

    int checks = 0;
    int errors = 0;

    button_event #(
        .CNT_W(4), .LONG_TICKS(8), .DCLICK_TICKS(5), .REPEAT_TICKS(3)
    ) dut (
        .CLK(CLK), .RST_N(RST_N), .PB_down(PB_down), .PB_up(PB_up),
        .CLICK(CLICK), .DCLICK(DCLICK), .LONG(LONG), .REPEAT(REPEAT), .HELD(HELD)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] b1(input int i);
        return 64'd1 << i;
    endfunction

    function automatic logic [63:0] rng(input int a, input int b);
        logic [63:0] v = '0;
        for (int i = a; i <= b; i++) v[i] = 1'b1;
        return v;
    endfunction

    function automatic logic [7:0] obs();
        return {3'b000, CLICK, DCLICK, LONG, REPEAT, HELD};
    endfunction

    // Index k is the value seen just before rising edge k; inputs set at
    // index k are sampled by edge k.
    task automatic run_seq(input string tag, input int n,
                           input logic [63:0] dn, input logic [63:0] up,
                           input logic [63:0] e_clk, input logic [63:0] e_dclk,
                           input logic [63:0] e_long, input logic [63:0] e_rep,
                           input logic [63:0] e_held, input logic [63:0] held_dc);
        logic [7:0] exp, care;
        for (int k = 0; k < n; k++) begin
            @(negedge CLK);
            exp  = {3'b000, e_clk[k], e_dclk[k], e_long[k], e_rep[k], e_held[k]};
            care = {7'h7F, ~held_dc[k]};
            check($sformatf("%s[%0d]", tag, k), obs() & care, exp & care);
            PB_down = dn[k];
            PB_up   = up[k];
        end
        $display("%s: %0d cycles compared", tag, n);
    endtask

    initial begin
        logic [63:0] z;
        z = '0;

        repeat (3) @(negedge CLK);
        check("reset_state", obs(), 8'h00);
        RST_N = 1'b1;

        run_seq("short_click", 14, b1(1), b1(4), b1(10), z, z, z, rng(2, 4), b1(5));
        run_seq("double_click", 14, b1(1) | b1(5), b1(3) | b1(7),
                z, b1(8), z, z, rng(2, 3) | rng(6, 7), z);
        run_seq("long_repeat", 30, b1(1), b1(21),
                z, z, b1(10), b1(13) | b1(16) | b1(19), rng(2, 21), z);
        run_seq("release_at_long_term", 20, b1(1), b1(9),
                b1(15), z, z, z, rng(2, 9), z);
        run_seq("both_in_idle", 16, b1(1) | b1(4), b1(1) | b1(3) | b1(5),
                b1(11), z, z, z, b1(5), z);
        run_seq("ignored_and_gap_race", 18, b1(1) | b1(2) | b1(3) | b1(10),
                b1(3) | b1(5) | b1(7) | b1(12),
                z, b1(13), z, z, rng(2, 5) | rng(11, 12), z);
        run_seq("press2_long", 20, b1(1) | b1(5), b1(3) | b1(15),
                b1(14), z, b1(14), z, rng(2, 3) | rng(6, 15), z);

        run_seq("rst_pre", 5, b1(1), z, z, z, z, z, rng(2, 4), z);
        @(negedge CLK);
        check("rst_held_before", obs(), 8'h01);
        RST_N = 1'b0;
        #1;
        check("rst_async", obs(), 8'h00);
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        run_seq("rst_post", 12, z, b1(1), z, z, z, z, z, z);
        run_seq("rst_first_press", 14, b1(1), b1(4), b1(10), z, z, z, rng(2, 4), b1(5));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
